// File: rtl/multicycle_ctrl.sv
// Control FSM for the shared multicycle MIPS datapath: decodes the latched opcode,
// drives mux selects and write enables, stalls on mem_ready, and counts retired instructions.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  op,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        iord,
  output logic        irwrite,
  output logic        memwrite,
  output logic        regwrite,
  output logic        regdst,
  output logic        memtoreg,
  output logic        alusrca,
  output logic [1:0]  alusrcb,
  output logic [1:0]  aluop,
  output logic [1:0]  pcsrc,
  output logic        pcen,
  output logic        illegal,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,  DECODE  = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB   = 4'd4,  MEMWR   = 4'd5,  RTYPEEX = 4'd6, RTYPEWB = 4'd7,
    BEQEX   = 4'd8,  ADDIEX  = 4'd9,  ADDIWB = 4'd10, JEX    = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW = 6'b100011, OP_SW = 6'b101011, OP_R = 6'b000000,
                         OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;

  state_t st, nst, dst;
  logic   retire, pcwrite, branch;

  always_ff @(posedge clk) begin
    if (rst) begin
      st      <= FETCH;
      retired <= 32'd0;
    end else begin
      st <= nst;
      if (retire) retired <= retired + 32'd1;
    end
  end

  always_comb begin
    nst    = FETCH;
    retire = 1'b0;
    case (st)
      FETCH:   nst = mem_ready ? DECODE : FETCH;
      DECODE:
        case (op)
          OP_LW, OP_SW: nst = MEMADR;
          OP_R:         nst = RTYPEEX;
          OP_BEQ:       nst = BEQEX;
          OP_ADDI:      nst = ADDIEX;
          OP_J:         nst = JEX;
          default:      nst = FETCH;
        endcase
      MEMADR:  nst = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:   nst = mem_ready ? MEMWB : MEMRD;
      MEMWB:   begin nst = FETCH; retire = 1'b1; end
      MEMWR:   begin nst = mem_ready ? FETCH : MEMWR; retire = mem_ready; end
      RTYPEEX: nst = RTYPEWB;
      RTYPEWB: begin nst = FETCH; retire = 1'b1; end
      BEQEX:   begin nst = FETCH; retire = 1'b1; end
      ADDIEX:  nst = ADDIWB;
      ADDIWB:  begin nst = FETCH; retire = 1'b1; end
      JEX:     begin nst = FETCH; retire = 1'b1; end
      default: nst = FETCH;
    endcase
  end

  // While in reset the outputs decode as FETCH with every enable masked off.
  always_comb begin
    dst      = rst ? FETCH : st;
    iord     = 1'b0;
    irwrite  = 1'b0;
    memwrite = 1'b0;
    regwrite = 1'b0;
    regdst   = 1'b0;
    memtoreg = 1'b0;
    alusrca  = 1'b0;
    alusrcb  = 2'b00;
    aluop    = 2'b00;
    pcsrc    = 2'b00;
    pcwrite  = 1'b0;
    branch   = 1'b0;
    illegal  = 1'b0;
    case (dst)
      FETCH: begin
        alusrcb = 2'b01;
        irwrite = mem_ready & ~rst;
        pcwrite = mem_ready & ~rst;
      end
      DECODE: begin
        alusrcb = 2'b11;
        illegal = !(op inside {OP_LW, OP_SW, OP_R, OP_BEQ, OP_ADDI, OP_J});
      end
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      MEMRD:   iord = 1'b1;
      MEMWB:   begin memtoreg = 1'b1; regwrite = 1'b1; end
      MEMWR:   begin iord = 1'b1; memwrite = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; aluop = 2'b10; end
      RTYPEWB: begin regdst = 1'b1; regwrite = 1'b1; end
      BEQEX:   begin alusrca = 1'b1; aluop = 2'b01; pcsrc = 2'b01; branch = 1'b1; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWB:  regwrite = 1'b1;
      JEX:     begin pcsrc = 2'b10; pcwrite = 1'b1; end
      default: ;
    endcase
  end

  assign pcen  = pcwrite | (branch & zero);
  assign state = st;

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM that sequences the shared 32-bit multicycle MIPS datapath: the ALU, the memory port, the register file and the 2:1/4:1 select muxes. It decodes the 6-bit opcode latched in the instruction register. Each cycle it drives every mux select and write enable, and it stalls on a memory-ready handshake. It also keeps a retired-instruction counter for debug.

## Interface
- No parameters.
- clk  in  1  rising-edge clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- op  in  6  opcode from the instruction register, bits [31:26].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory access completes this cycle.
- iord  out  1  address mux select: 0 = PC, 1 = ALUOut.
- irwrite  out  1  instruction register load.
- memwrite  out  1  memory write strobe.
- regwrite  out  1  register file write.
- regdst  out  1  write-register mux: 0 = rt, 1 = rd.
- memtoreg  out  1  write-data mux: 0 = ALUOut, 1 = MDR.
- alusrca  out  1  ALU A mux: 0 = PC, 1 = A register.
- alusrcb  out  2  ALU B mux: 00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2.
- aluop  out  2  00 = add, 01 = sub, 10 = decode funct.
- pcsrc  out  2  PC mux: 00 = ALUResult, 01 = ALUOut, 10 = jump target.
- pcen  out  1  PC register enable.
- illegal  out  1  one-cycle pulse for an undecodable opcode.
- state  out  4  current state, for debug.
- retired  out  32  count of completed instructions.

## Operation
- State encodings:
  - 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 RTYPEEX, 7 RTYPEWB.
  - 8 BEQEX, 9 ADDIEX, 10 ADDIWB, 11 JEX.
  - Encodings 12–15 are unreachable; if entered, go to FETCH.
- Transitions:
  - FETCH goes to DECODE when mem_ready = 1, otherwise holds in FETCH.
  - DECODE dispatches on op:
    - 100011 (lw) or 101011 (sw) → MEMADR.
    - 000000 (R-type) → RTYPEEX.
    - 000100 (beq) → BEQEX.
    - 001000 (addi) → ADDIEX.
    - 000010 (j) → JEX.
    - Any other op → FETCH, with illegal = 1 for that DECODE cycle.
  - MEMADR → MEMRD for lw, → MEMWR for sw.
  - MEMRD → MEMWB when mem_ready = 1, otherwise holds.
  - MEMWR → FETCH when mem_ready = 1, otherwise holds.
  - RTYPEEX → RTYPEWB → FETCH.
  - ADDIEX → ADDIWB → FETCH.
  - BEQEX → FETCH; JEX → FETCH.
- Outputs are decoded from the state only; any signal not listed for a state is 0.
  - FETCH: alusrcb = 01, irwrite = mem_ready, pcwrite = mem_ready.
  - DECODE: alusrcb = 11.
  - MEMADR: alusrca = 1, alusrcb = 10.
  - MEMRD: iord = 1.
  - MEMWB: memtoreg = 1, regwrite = 1.
  - MEMWR: iord = 1, memwrite = 1. memwrite is held for every wait cycle.
  - RTYPEEX: alusrca = 1, aluop = 10.
  - RTYPEWB: regdst = 1, regwrite = 1.
  - BEQEX: alusrca = 1, aluop = 01, pcsrc = 01, branch = 1.
  - ADDIEX: alusrca = 1, alusrcb = 10.
  - ADDIWB: regwrite = 1.
  - JEX: pcsrc = 10, pcwrite = 1.
- pcen = pcwrite | (branch & zero). pcwrite and branch are internal signals.
- retired increments by 1, wrapping modulo 2^32, on the clock edge that leaves each of these states:
  - MEMWB, MEMWR (only when mem_ready = 1), RTYPEWB, ADDIWB, BEQEX, JEX.
  - An illegal opcode does not increment retired.

## Timing
- Reset:
  - Any edge with rst = 1 sets state to FETCH and retired to 0.
  - While rst = 1, irwrite, memwrite, regwrite, pcen and illegal are forced to 0. Select outputs show their FETCH values.
- Reset mid-instruction aborts the instruction with no further enables. It takes priority over mem_ready and over the next-state logic.
- Cycles per instruction with mem_ready held at 1:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Each wait cycle in FETCH, MEMRD or MEMWR adds one cycle.
- The handshake is sampled on the same edge that advances the state. There is no requirement for mem_ready to arrive after a request.
- pcen in BEQEX follows zero combinationally within the cycle.

## Test plan
- Reset and fetch:
  - Stimulus: rst = 1 for 2 cycles, then mem_ready = 0 for 3 cycles.
  - Required: state = 0, pcen = 0 and irwrite = 0 throughout.
  - Then mem_ready = 1: irwrite = 1 and pcen = 1 for one cycle, and state = 1 on the next edge.
- lw with mem_ready = 1:
  - Required state sequence: 0, 1, 2, 3, 4, 0.
  - regwrite = 1 and memtoreg = 1 only in state 4; retired goes from 0 to 1.
- sw with mem_ready low for 2 cycles in MEMWR:
  - Required: memwrite = 1 for 3 cycles, then state = 0.
  - retired increments once; regwrite stays 0 throughout.
- beq:
  - With zero = 1: pcen = 1 and pcsrc = 01 in state 8.
  - With zero = 0: pcen = 0. Both cases return to state 0.
- R-type, addi and j:
  - R-type: regdst = 1 in state 7.
  - addi: alusrcb = 10 in state 9, and regwrite = 1 with regdst = 0 in state 10.
  - j: pcsrc = 10 and pcen = 1 in state 11.
- Illegal opcode and reset abort:
  - op = 111111 in DECODE: illegal = 1 for one cycle, next state 0, retired unchanged.
  - rst asserted in state 3: next state 0, retired = 0, no regwrite.
